imem_program_writer: RTL and testbench



---
 rtl/imem_program_writer_if.sv | 35 +++
 rtl/imem_program_writer.sv | 93 +++++++++
 tb/tb_imem_program_writer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/imem_program_writer_if.sv
// imem_program_writer_if: request, IMEM write and status signals of the program writer.
// The master drives requests and observes status; the slave is the writer itself.
interface imem_program_writer_if #(
    parameter int ADDR_W = 10
);
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic              in_rtype;
    logic [5:0]        in_code;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [4:0]        in_shamt;
    logic [15:0]       in_imm;
    logic              in_last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   count;
    logic              err_illegal;
    logic              err_full;

    modport master (
        output start, in_valid, in_rtype, in_code, in_rs, in_rt, in_rd, in_shamt, in_imm, in_last,
        input  in_ready, imem_we, imem_addr, imem_wdata, busy, done, count, err_illegal, err_full
    );

    modport slave (
        input  start, in_valid, in_rtype, in_code, in_rs, in_rt, in_rd, in_shamt, in_imm, in_last,
        output in_ready, imem_we, imem_addr, imem_wdata, busy, done, count, err_illegal, err_full
    );
endinterface

// File: rtl/imem_program_writer.sv
// imem_program_writer: encodes R/I-type requests into MIPS words and streams them into IMEM.
// Only the instruction set understood by the EX-stage ALU decoder is accepted.
module imem_program_writer #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input logic                   clk,
    input logic                   rst_n,
    imem_program_writer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       wdata_d;
    logic              we_q;
    logic [ADDR_W:0]   count_q;
    logic              err_illegal_q;
    logic              err_full_q;
    logic              shift_imm;
    logic              legal;
    logic              hs;
    logic              at_top;

    always_comb begin
        shift_imm = bus.in_rtype && (bus.in_code inside {6'h00, 6'h02, 6'h03});
        legal     = bus.in_rtype
                  ? (bus.in_code inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h21, 6'h23,
                                         6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B})
                  : (bus.in_code inside {6'h04, 6'h05, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E,
                                         6'h0F, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B});
        // Immediate shifts carry no rs; every other R-type carries no shamt; LUI carries no rs.
        wdata_d   = bus.in_rtype
                  ? {6'h00, shift_imm ? 5'd0 : bus.in_rs, bus.in_rt, bus.in_rd,
                     shift_imm ? bus.in_shamt : 5'd0, bus.in_code}
                  : {bus.in_code, (bus.in_code == 6'h0F) ? 5'd0 : bus.in_rs, bus.in_rt, bus.in_imm};
        hs        = (state_q == RUN) && bus.in_valid;
        at_top    = ptr_q == '1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ptr_q         <= ADDR_W'(BASE_ADDR);
            addr_q        <= ADDR_W'(BASE_ADDR);
            wdata_q       <= '0;
            we_q          <= 1'b0;
            count_q       <= '0;
            err_illegal_q <= 1'b0;
            err_full_q    <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                IDLE: if (bus.start) begin
                    state_q       <= RUN;
                    ptr_q         <= ADDR_W'(BASE_ADDR);
                    addr_q        <= ADDR_W'(BASE_ADDR);
                    count_q       <= '0;
                    err_illegal_q <= 1'b0;
                    err_full_q    <= 1'b0;
                end
                RUN: if (hs) begin
                    if (legal) begin
                        we_q    <= 1'b1;
                        addr_q  <= ptr_q;
                        wdata_q <= wdata_d;
                        count_q <= count_q + 1'b1;
                        if (!at_top) ptr_q <= ptr_q + 1'b1;
                    end else begin
                        err_illegal_q <= 1'b1;
                    end
                    // The top word ends the load; without in_last that is an overflow.
                    if (bus.in_last || (legal && at_top)) state_q <= DONE;
                    if (legal && at_top && !bus.in_last) err_full_q <= 1'b1;
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready    = state_q == RUN;
    assign bus.busy        = state_q != IDLE;
    assign bus.done        = state_q == DONE;
    assign bus.imem_we     = we_q;
    assign bus.imem_addr   = addr_q;
    assign bus.imem_wdata  = wdata_q;
    assign bus.count       = count_q;
    assign bus.err_illegal = err_illegal_q;
    assign bus.err_full    = err_full_q;
endmodule

// File: tb/tb_imem_program_writer.sv
// tb_imem_program_writer: table-driven vectors with a write scoreboard, plus full and reset sequences.
module tb_imem_program_writer;
    typedef struct {
        logic        rtype;
        logic [5:0]  code;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [15:0] imm;
        logic        last;
        logic        legal;
        logic [31:0] word;
    } vec_t;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] word;
        logic [10:0] cnt;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    vec_t vt[15];
    wr_t  sbq[$];
    wr_t  e;
    int   exp_addr;
    int   exp_cnt;
    bit   any_ill;

    imem_program_writer_if #(.ADDR_W(10)) bus_a ();
    imem_program_writer_if #(.ADDR_W(2))  bus_b ();

    imem_program_writer #(.ADDR_W(10), .BASE_ADDR(0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    imem_program_writer #(.ADDR_W(2),  .BASE_ADDR(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus_a.imem_we) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got write addr %h data %h, required no write",
                         bus_a.imem_addr, bus_a.imem_wdata);
            end else begin
                e = sbq.pop_front();
                chk("wr_addr", 32'(bus_a.imem_addr), 32'(e.addr));
                chk("wr_data", bus_a.imem_wdata, e.word);
                chk("wr_count", 32'(bus_a.count), 32'(e.cnt));
            end
        end
    end

    task automatic drive(input bit b, input vec_t v, input logic last);
        if (b) begin
            bus_b.in_valid = 1'b1; bus_b.in_rtype = v.rtype; bus_b.in_code = v.code;
            bus_b.in_rs = v.rs; bus_b.in_rt = v.rt; bus_b.in_rd = v.rd;
            bus_b.in_shamt = v.sh; bus_b.in_imm = v.imm; bus_b.in_last = last;
        end else begin
            bus_a.in_valid = 1'b1; bus_a.in_rtype = v.rtype; bus_a.in_code = v.code;
            bus_a.in_rs = v.rs; bus_a.in_rt = v.rt; bus_a.in_rd = v.rd;
            bus_a.in_shamt = v.sh; bus_a.in_imm = v.imm; bus_a.in_last = last;
        end
    endtask

    task automatic start_a();
        @(posedge clk); #1 bus_a.start = 1'b1;
        @(posedge clk); #1 bus_a.start = 1'b0;
        exp_addr = 0;
        exp_cnt  = 0;
        any_ill  = 1'b0;
    endtask

    task automatic send_a(input int i);
        drive(1'b0, vt[i], vt[i].last);
        @(negedge clk);
        chk("ready", 32'(bus_a.in_ready), 32'd1);
        if (vt[i].legal) begin
            exp_cnt++;
            sbq.push_back('{addr: 10'(exp_addr), word: vt[i].word, cnt: 11'(exp_cnt)});
            exp_addr++;
        end else begin
            any_ill = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    task automatic run_prog(input int lo, input int hi, input bit do_start);
        if (do_start) start_a();
        for (int i = lo; i <= hi; i++) send_a(i);
        bus_a.in_valid = 1'b0;
        @(negedge clk);
        chk("done_pulse", 32'(bus_a.done), 32'd1);
        chk("done_we", 32'(bus_a.imem_we), 32'(vt[hi].legal));
        chk("done_ready", 32'(bus_a.in_ready), 32'd0);
        chk("done_count", 32'(bus_a.count), 32'(exp_cnt));
        chk("err_illegal", 32'(bus_a.err_illegal), 32'(any_ill));
        chk("err_full_a", 32'(bus_a.err_full), 32'd0);
        @(negedge clk);
        chk("idle_busy", 32'(bus_a.busy), 32'd0);
        chk("idle_done", 32'(bus_a.done), 32'd0);
    endtask

    task automatic prog_b(input bit last4);
        int idx[5] = '{1, 2, 4, 7, 8};
        @(posedge clk); #1 bus_b.start = 1'b1;
        @(posedge clk); #1 bus_b.start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, vt[idx[k]], last4 && k == 3);
            @(negedge clk);
            if (k == 0) begin
                chk("b_count_clr", 32'(bus_b.count), 32'd0);
                chk("b_err_full_clr", 32'(bus_b.err_full), 32'd0);
            end else begin
                chk("b_we", 32'(bus_b.imem_we), 32'd1);
                chk("b_addr", 32'(bus_b.imem_addr), 32'(k - 1));
                chk("b_data", bus_b.imem_wdata, vt[idx[k-1]].word);
            end
            if (k < 4) begin
                chk("b_ready", 32'(bus_b.in_ready), 32'd1);
            end else begin
                chk("b_full_ready", 32'(bus_b.in_ready), 32'd0);
                chk("b_done", 32'(bus_b.done), 32'd1);
                chk("b_count", 32'(bus_b.count), 32'd4);
                chk("b_err_full", 32'(bus_b.err_full), 32'(!last4));
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("b_post_busy", 32'(bus_b.busy), 32'd0);
        chk("b_post_we", 32'(bus_b.imem_we), 32'd0);
        chk("b_post_count", 32'(bus_b.count), 32'd4);
        chk("b_post_err_full", 32'(bus_b.err_full), 32'(!last4));
        bus_b.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200000");
        $fatal(1);
    end

    initial begin
        vt[0]  = '{1'b1, 6'h21, 5'd1,  5'd2,  5'd3,  5'd7,  16'h0000, 1'b1, 1'b1, 32'h00221821};
        vt[1]  = '{1'b1, 6'h00, 5'd5,  5'd2,  5'd4,  5'd3,  16'h0000, 1'b0, 1'b1, 32'h000220C0};
        vt[2]  = '{1'b0, 6'h0F, 5'd9,  5'd8,  5'd0,  5'd0,  16'h1234, 1'b0, 1'b1, 32'h3C081234};
        vt[3]  = '{1'b0, 6'h2B, 5'd29, 5'd31, 5'd0,  5'd0,  16'hFFFC, 1'b1, 1'b1, 32'hAFBFFFFC};
        vt[4]  = '{1'b0, 6'h09, 5'd1,  5'd2,  5'd0,  5'd0,  16'h0005, 1'b0, 1'b1, 32'h24220005};
        vt[5]  = '{1'b1, 6'h20, 5'd1,  5'd2,  5'd3,  5'd0,  16'h0000, 1'b0, 1'b0, 32'h00000000};
        vt[6]  = '{1'b0, 6'h0D, 5'd4,  5'd5,  5'd0,  5'd0,  16'hABCD, 1'b1, 1'b1, 32'h3485ABCD};
        vt[7]  = '{1'b1, 6'h07, 5'd3,  5'd4,  5'd5,  5'd9,  16'h0000, 1'b0, 1'b1, 32'h00642807};
        vt[8]  = '{1'b0, 6'h04, 5'd1,  5'd2,  5'd0,  5'd0,  16'h0010, 1'b0, 1'b1, 32'h10220010};
        vt[9]  = '{1'b0, 6'h00, 5'd1,  5'd2,  5'd0,  5'd0,  16'h0001, 1'b0, 1'b0, 32'h00000000};
        vt[10] = '{1'b1, 6'h2B, 5'd31, 5'd31, 5'd31, 5'd31, 16'h0000, 1'b0, 1'b1, 32'h03FFF82B};
        vt[11] = '{1'b0, 6'h25, 5'd2,  5'd3,  5'd0,  5'd0,  16'h8000, 1'b0, 1'b1, 32'h94438000};
        vt[12] = '{1'b1, 6'h03, 5'd7,  5'd1,  5'd2,  5'd31, 16'h0000, 1'b0, 1'b1, 32'h000117C3};
        vt[13] = '{1'b0, 6'h08, 5'd1,  5'd2,  5'd0,  5'd0,  16'h0003, 1'b0, 1'b0, 32'h00000000};
        vt[14] = '{1'b1, 6'h01, 5'd1,  5'd2,  5'd3,  5'd0,  16'h0000, 1'b1, 1'b0, 32'h00000000};

        bus_a.start = 1'b0; bus_a.in_valid = 1'b0; bus_a.in_rtype = 1'b0; bus_a.in_code = '0;
        bus_a.in_rs = '0; bus_a.in_rt = '0; bus_a.in_rd = '0; bus_a.in_shamt = '0;
        bus_a.in_imm = '0; bus_a.in_last = 1'b0;
        bus_b.start = 1'b0; bus_b.in_valid = 1'b0; bus_b.in_rtype = 1'b0; bus_b.in_code = '0;
        bus_b.in_rs = '0; bus_b.in_rt = '0; bus_b.in_rd = '0; bus_b.in_shamt = '0;
        bus_b.in_imm = '0; bus_b.in_last = 1'b0;

        #12;
        chk("rst_we", 32'(bus_a.imem_we), 32'd0);
        chk("rst_addr", 32'(bus_a.imem_addr), 32'd0);
        chk("rst_wdata", bus_a.imem_wdata, 32'd0);
        chk("rst_ready", 32'(bus_a.in_ready), 32'd0);
        chk("rst_busy", 32'(bus_a.busy), 32'd0);
        chk("rst_done", 32'(bus_a.done), 32'd0);
        chk("rst_count", 32'(bus_a.count), 32'd0);
        chk("rst_err_illegal", 32'(bus_a.err_illegal), 32'd0);
        chk("rst_err_full", 32'(bus_a.err_full), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        run_prog(0, 0, 1'b1);
        run_prog(1, 3, 1'b1);
        run_prog(4, 6, 1'b1);
        run_prog(0, 0, 1'b1);
        run_prog(7, 14, 1'b1);

        start_a();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1 bus_a.start = (i == 4);
        end
        @(negedge clk);
        chk("run_hold_busy", 32'(bus_a.busy), 32'd1);
        chk("run_hold_ready", 32'(bus_a.in_ready), 32'd1);
        chk("run_hold_count", 32'(bus_a.count), 32'd0);
        chk("run_hold_addr", 32'(bus_a.imem_addr), 32'd0);
        @(posedge clk); #1;
        run_prog(0, 0, 1'b0);

        start_a();
        send_a(1);
        send_a(5);
        send_a(2);
        bus_a.in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_count", 32'(bus_a.count), 32'd2);
        chk("pre_rst_err", 32'(bus_a.err_illegal), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_we", 32'(bus_a.imem_we), 32'd0);
        chk("abort_addr", 32'(bus_a.imem_addr), 32'd0);
        chk("abort_wdata", bus_a.imem_wdata, 32'd0);
        chk("abort_busy", 32'(bus_a.busy), 32'd0);
        chk("abort_ready", 32'(bus_a.in_ready), 32'd0);
        chk("abort_count", 32'(bus_a.count), 32'd0);
        chk("abort_err", 32'(bus_a.err_illegal), 32'd0);
        #4 rst_n = 1'b1;
        run_prog(0, 0, 1'b1);

        prog_b(1'b0);
        prog_b(1'b1);

        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
